// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache/memory hierarchy: the RAM handshake encoding,
// the memory word type and the arbiter grant states.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RAMSTATE_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    // RAM handshake: ACCESS marks the single cycle in which the access completes
    typedef enum logic [RAMSTATE_W-1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter grant: nobody, icache or dcache owns the RAM port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter of cycles the icache has spent waiting behind a dcache
// grant. Clear has priority over increment; at_max flags the saturation value.
//
// Ports:
//   CLK     clock
//   nRST    asynchronous active-low reset
//   clr     return the count to zero
//   inc     count one more waiting cycle (ignored once saturated)
//   at_max  count equals MAX
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // Count up to MAX and hold there until cleared
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-ported RAM between icache and dcache. dcache has priority;
// a starving icache is let in only at a dcache block boundary (completion of
// the second word, daddr[2]==1) so fills, writebacks and flushes never split.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   iREN, iaddr / iload, iwait     icache request / data and stall
//   dREN, dWEN, daddr, dstore      dcache request, address and write data
//   dload, dwait                   dcache data and stall
//   ramREN, ramWEN, ramaddr,
//   ramstore                       RAM strobes, address, write data
//   ramload, ramstate              RAM read data and handshake state
//   ram_err                        sticky: ERROR seen while a cache was granted
//
// The grant state is registered; strobes, address and wait are decoded from
// the grant and the live cache/RAM signals so a completion is reported in the
// same cycle the RAM shows ACCESS.
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    arb_state_t state;
    ramstate_t  rs;
    logic       force_i;
    logic       d_req;
    logic       i_done;
    logic       d_done;
    logic       starving;
    logic       starve_at_max;
    logic       force_eff;
    logic       granted;

    assign rs      = ramstate_t'(ramstate);
    assign d_req   = dREN | dWEN;
    assign granted = (state != IDLE);

    // A completion is the granted, still-requesting side seeing ACCESS
    assign i_done  = (state == IGNT) && iREN  && (rs == ACCESS);
    assign d_done  = (state == DGNT) && d_req && (rs == ACCESS);

    // icache counts as starving only while it waits behind a dcache grant
    assign starving  = (state == DGNT) && iREN;
    assign force_eff = force_i | starve_at_max;

    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (!starving),
        .inc    (starving),
        .at_max (starve_at_max)
    );

    // Read data goes straight through; the wait lines qualify it
    assign iload = ramload;
    assign dload = ramload;
    assign iwait = !i_done;
    assign dwait = !d_done;

    // Grant FSM, forced-icache flag and sticky error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            force_i <= 1'b0;
            ram_err <= 1'b0;
        end else begin
            if (granted && (rs == ERROR)) begin
                ram_err <= 1'b1;
            end

            // Forcing is pointless once icache stops asking or has been served
            if (starve_at_max) begin
                force_i <= 1'b1;
            end else if (i_done || !iREN) begin
                force_i <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (d_req) begin
                        state <= DGNT;
                    end else if (iREN) begin
                        state <= IGNT;
                    end
                end
                IGNT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (i_done) begin
                        state <= d_req ? DGNT : IGNT;
                    end
                end
                DGNT: begin
                    // Hand over only after the second word of a block
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (d_done && daddr[2] && force_eff && iREN) begin
                        state <= IGNT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux: only the granted side drives strobes, write beats read
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (dWEN) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = dREN;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. The bench plays the RAM by driving ramstate
// cycle by cycle; inputs change 1 time unit after the rising edge and outputs
// are compared 2 units later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .STARVE_MAX (8),
        .CNT_W      (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
        #3;
        checks++; if (iwait !== 1'b1)   begin failures++; $display("FAIL rst_iwait got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1)   begin failures++; $display("FAIL rst_dwait got %b want 1", dwait); end
        checks++; if (ramREN !== 1'b0)  begin failures++; $display("FAIL rst_ramREN got %b want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0)  begin failures++; $display("FAIL rst_ramWEN got %b want 0", ramWEN); end
        checks++; if (ram_err !== 1'b0) begin failures++; $display("FAIL rst_ram_err got %b want 0", ram_err); end
        @(negedge CLK);
        nRST = 1'b1;
        tick; tick;
        #2;
        checks++; if (iwait !== 1'b1)   begin failures++; $display("FAIL post_rst_iwait got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1)   begin failures++; $display("FAIL post_rst_dwait got %b want 1", dwait); end
        checks++; if (ramREN !== 1'b0)  begin failures++; $display("FAIL post_rst_ramREN got %b want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0)  begin failures++; $display("FAIL post_rst_ramWEN got %b want 0", ramWEN); end
        checks++; if (ram_err !== 1'b0) begin failures++; $display("FAIL post_rst_ram_err got %b want 0", ram_err); end
    endtask

    // icache fetch: cycle 0 request in IDLE, cycles 1..4 granted, ACCESS on 4
    task automatic test_ifetch;
        tick;
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'h3C010001; ramstate = RS_FREE;
        #2;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL if_c0_ramREN got %b want 0", ramREN); end
        for (int k = 1; k <= 4; k++) begin
            tick;
            ramstate = (k == 1) ? RS_FREE : ((k == 4) ? RS_ACCESS : RS_BUSY);
            #2;
            checks++; if (ramREN !== 1'b1)   begin failures++; $display("FAIL if_ramREN c%0d got %b want 1", k, ramREN); end
            checks++; if (ramaddr !== 32'h40) begin failures++; $display("FAIL if_ramaddr c%0d got %h want 00000040", k, ramaddr); end
            checks++; if (iwait !== ((k == 4) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL if_iwait c%0d got %b want %b", k, iwait, (k != 4)); end
            checks++; if (dwait !== 1'b1)    begin failures++; $display("FAIL if_dwait c%0d got %b want 1", k, dwait); end
        end
        checks++; if (iload !== 32'h3C010001) begin failures++; $display("FAIL if_iload got %h want 3c010001", iload); end
        tick;
        iREN = 1'b0; ramstate = RS_FREE;
        #2;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL if_drop_ramREN got %b want 0", ramREN); end
        checks++; if (iwait !== 1'b1)  begin failures++; $display("FAIL if_drop_iwait got %b want 1", iwait); end
        tick;
    endtask

    // Simultaneous requests: dcache first, icache only after dREN drops
    task automatic test_priority;
        tick;
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = RS_FREE;
        #2;
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL pr_c0_wait got i=%b d=%b want 1 1", iwait, dwait); end
        tick;
        ramstate = RS_BUSY;
        #2;
        checks++; if (ramaddr !== 32'h100) begin failures++; $display("FAIL pr_c1_ramaddr got %h want 00000100", ramaddr); end
        checks++; if (ramREN !== 1'b1)     begin failures++; $display("FAIL pr_c1_ramREN got %b want 1", ramREN); end
        checks++; if (iwait !== 1'b1)      begin failures++; $display("FAIL pr_c1_iwait got %b want 1", iwait); end
        tick;
        ramstate = RS_ACCESS; ramload = 32'h12345678;
        #2;
        checks++; if (dwait !== 1'b0)          begin failures++; $display("FAIL pr_c2_dwait got %b want 0", dwait); end
        checks++; if (dload !== 32'h12345678)  begin failures++; $display("FAIL pr_c2_dload got %h want 12345678", dload); end
        checks++; if (iwait !== 1'b1)          begin failures++; $display("FAIL pr_c2_iwait got %b want 1", iwait); end
        tick;
        dREN = 1'b0; ramstate = RS_FREE;
        #2;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL pr_c3 got ramREN=%b iwait=%b want 0 1", ramREN, iwait); end
        tick;
        #2;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL pr_c4_idle_ramREN got %b want 0", ramREN); end
        tick;
        #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin failures++; $display("FAIL pr_c5_igrant got ramREN=%b addr=%h want 1 00000044", ramREN, ramaddr); end
        tick;
        iREN = 1'b0;
        tick;
    endtask

    // Two-word block write with dREN also high; icache arrives mid-block
    task automatic test_block_write;
        tick;
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD0000; ramstate = RS_FREE;
        #2;
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL bw_c0_ramWEN got %b want 0", ramWEN); end
        tick;
        ramstate = RS_BUSY;
        #2;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL bw_c1_strobes got W=%b R=%b want 1 0", ramWEN, ramREN); end
        checks++; if (ramaddr !== 32'h200 || ramstore !== 32'hDEAD0000) begin failures++; $display("FAIL bw_c1_bus got %h/%h want 00000200/dead0000", ramaddr, ramstore); end
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL bw_c1_dwait got %b want 1", dwait); end
        tick;
        ramstate = RS_ACCESS;
        #2;
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL bw_c2_dwait got %b want 0", dwait); end
        tick;
        daddr = 32'h204; dstore = 32'hDEAD0004; iREN = 1'b1; iaddr = 32'h48; ramstate = RS_BUSY;
        #2;
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h204 || ramstore !== 32'hDEAD0004) begin failures++; $display("FAIL bw_c3 got W=%b %h/%h want 1 00000204/dead0004", ramWEN, ramaddr, ramstore); end
        checks++; if (dwait !== 1'b1 || iwait !== 1'b1) begin failures++; $display("FAIL bw_c3_wait got d=%b i=%b want 1 1", dwait, iwait); end
        tick;
        ramstate = RS_ACCESS;
        #2;
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1 || ramWEN !== 1'b1) begin failures++; $display("FAIL bw_c4 got d=%b i=%b W=%b want 0 1 1", dwait, iwait, ramWEN); end
        tick;
        dWEN = 1'b0; dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
        #2;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin failures++; $display("FAIL bw_c5 got W=%b R=%b want 0 0", ramWEN, ramREN); end
        tick;
    endtask

    // dcache streams words (BUSY, ACCESS each); icache starves from A1.
    // Count reaches 8 in A9; 0x310 (bit2=0) must not hand over; 0x314 does.
    task automatic test_starvation;
        logic [31:0] a;
        tick;
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300; ramstate = RS_FREE;
        ramload = 32'hCAFE0080;
        #2;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL st_c0_ramREN got %b want 0", ramREN); end
        for (int k = 1; k <= 12; k++) begin
            tick;
            a = 32'h300 + 32'(4 * ((k - 1) / 2));
            daddr = a;
            ramstate = (k % 2 == 1) ? RS_BUSY : RS_ACCESS;
            #2;
            checks++; if (ramaddr !== a) begin failures++; $display("FAIL st_ramaddr A%0d got %h want %h", k, ramaddr, a); end
            checks++; if (dwait !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL st_dwait A%0d got %b want %b", k, dwait, (k % 2 == 1)); end
            checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL st_iwait A%0d got %b want 1", k, iwait); end
        end
        tick;
        daddr = 32'h318; ramstate = RS_BUSY;
        #2;
        checks++; if (ramaddr !== 32'h80 || ramREN !== 1'b1) begin failures++; $display("FAIL st_A13_igrant got addr=%h R=%b want 00000080 1", ramaddr, ramREN); end
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL st_A13_dwait got %b want 1", dwait); end
        tick;
        ramstate = RS_ACCESS;
        #2;
        checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL st_A14_wait got i=%b d=%b want 0 1", iwait, dwait); end
        checks++; if (iload !== 32'hCAFE0080) begin failures++; $display("FAIL st_A14_iload got %h want cafe0080", iload); end
        tick;
        ramstate = RS_FREE;
        #2;
        checks++; if (ramaddr !== 32'h318 || ramREN !== 1'b1) begin failures++; $display("FAIL st_A15_dregrant got addr=%h R=%b want 00000318 1", ramaddr, ramREN); end
        tick;
        iREN = 1'b0; dREN = 1'b0;
        tick; tick;
    endtask

    // ERROR sets the sticky flag without completing; async reset mid-access
    task automatic test_error_reset;
        tick;
        dREN = 1'b1; daddr = 32'h400; ramstate = RS_FREE;
        #2;
        checks++; if (ram_err !== 1'b0) begin failures++; $display("FAIL er_c0_ram_err got %b want 0", ram_err); end
        tick;
        ramstate = RS_ERROR;
        #2;
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b1) begin failures++; $display("FAIL er_c1 got d=%b R=%b want 1 1", dwait, ramREN); end
        tick;
        #2;
        checks++; if (ram_err !== 1'b1) begin failures++; $display("FAIL er_c2_ram_err got %b want 1", ram_err); end
        checks++; if (ramaddr !== 32'h400 || dwait !== 1'b1) begin failures++; $display("FAIL er_c2_hold got addr=%h d=%b want 00000400 1", ramaddr, dwait); end
        tick;
        ramstate = RS_BUSY;
        #2;
        checks++; if (ramREN !== 1'b1 || ram_err !== 1'b1) begin failures++; $display("FAIL er_c3_pre got R=%b err=%b want 1 1", ramREN, ram_err); end
        nRST = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin failures++; $display("FAIL er_rst_strobes got R=%b W=%b want 0 0", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL er_rst_ramaddr got %h want 00000000", ramaddr); end
        checks++; if (ram_err !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL er_rst_flags got err=%b d=%b want 0 1", ram_err, dwait); end
        dREN = 1'b0; ramstate = RS_FREE;
        @(negedge CLK);
        nRST = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_ifetch;
        test_priority;
        test_block_write;
        test_starvation;
        test_error_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequential arbiter sharing the single-ported RAM between the instruction cache and the data cache. It takes word requests from both caches, grants one requester at a time, and drives the RAM strobes and address. It returns wait/load to each cache and enforces dcache priority with a bounded-starvation guarantee for instruction fetch. It sits between icache/dcache and the RAM model, in the memory_control slot of the caches hierarchy.

Parameters:
STARVE_MAX, 8, icache-waiting cycles under dcache grant before icache is forced in at the next block boundary
CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  icache read request
iaddr  in  32  icache word address
iload  out  32  instruction data to icache
iwait  out  1  icache stall; 0 for exactly the completing cycle
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dload  out  32  read data to dcache
dwait  out  1  dcache stall; 0 for exactly the completing cycle
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
ram_err  out  1  sticky, set on ERROR seen while granted

Behaviour:
- States: IDLE, IGNT, DGNT. Grant is registered: a request seen in IDLE drives the RAM from the next cycle. Arbitration adds 1 cycle of latency.
- Reset: state=IDLE, starve_cnt=0, force_i=0, ram_err=0. Outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1. iload=dload=ramload at all times (pass-through).
- IDLE: (dREN|dWEN) goes to DGNT; else iREN goes to IGNT; else stay. dcache wins simultaneous requests.
- IGNT: ramREN=iREN, ramaddr=iaddr. The access completes when ramstate==ACCESS, and that cycle has iwait=0.
  - On completion: dcache request pending goes to DGNT; else iREN stays in IGNT (new address next cycle); else IDLE. force_i clears.
  - iREN dropped before completion goes to IDLE with no strobes.
- DGNT: ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. dWEN overrides dREN when both are asserted.
  - Else ramREN=dREN.
  - The access completes when ramstate==ACCESS, and that cycle has dwait=0.
  - Grant persists while dREN|dWEN remains asserted, so a two-word block fill/writeback and a halt flush are never split.
  - Both requests dropped goes to IDLE.
- Starvation:
  - In DGNT with iREN=1, starve_cnt increments each cycle, saturating at STARVE_MAX; otherwise it is 0.
  - At starve_cnt==STARVE_MAX, force_i=1.
  - With force_i=1, a dcache completion at daddr[2]==1 (second word of a block) goes to IGNT for one transaction, then DGNT if dcache is still requesting.
  - Never switches at daddr[2]==0.
- Wait rules: a non-granted requester always sees wait=1. wait=1 during FREE/BUSY/ERROR.
- ERROR while granted sets ram_err (held until reset). The state does not advance.
- Strobes are deasserted in the cycle after completion if the grant changes; there are no overlapping strobes.
- Reset mid-transaction: immediate IDLE, strobes low. No partial completion is reported.

Decomposition:
- cpu_types_pkg gets ramstate_t (FREE/BUSY/ACCESS/ERROR), word_t, and arb_state_t {IDLE, IGNT, DGNT}.
- Optional sub-module arb_starve_ctr: saturating counter with clear and flag output.
- Arbiter FSM and output mux stay in mem_arbiter.

Test Plan:
1. Reset with all requests low -> iwait=dwait=1, ramREN=ramWEN=0, ram_err=0. These hold after nRST rises.
2. iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0x3C010001 -> IGNT on cycle 1, ramREN=1, ramaddr=0x40, iwait=0 only on cycle 4, iload=0x3C010001.
3. iREN and dREN both asserted in IDLE, daddr=0x100 -> DGNT, ramaddr=0x100, iwait stays 1 until the dcache word completes and dREN drops.
4. dWEN=1 block write 0x200/0x204, dstore=0xDEAD0000/0xDEAD0004 -> ramWEN=1 for both words with no grant change between them; dwait=0 once per word.
5. iREN held with back-to-back dcache reads, STARVE_MAX=8 -> starve_cnt reaches 8, icache granted right after the 0x..4 word completes, never after a 0x..0 word.
6. ramstate=ERROR during DGNT -> ram_err=1, dwait=1; nRST low mid-access -> IDLE, strobes 0 asynchronously.
